// File: rtl/gray_counter.sv
// Up/down binary counter with a registered Gray-code image and a one-cycle wrap pulse.
// Parallel load accepts either binary or Gray-coded values.
module gray_counter #(
  parameter int WIDTH     = 4,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic             load_gray,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] bin_out,
  output logic [WIDTH-1:0] gray_out,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] RST_BIN  = RESET_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] RST_GRAY = RST_BIN ^ (RST_BIN >> 1);
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [WIDTH-1:0] to_bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b = '0;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [WIDTH-1:0] bin_p0;
  logic             wrap_p0;

  // Stage 0: next count; load wins over en, and only a count step can wrap.
  always_comb begin
    bin_p0  = bin_out;
    wrap_p0 = 1'b0;
    if (load) begin
      bin_p0 = load_gray ? to_bin(load_val) : load_val;
    end else if (en) begin
      if (up_dn) begin
        bin_p0  = bin_out + 1'b1;
        wrap_p0 = (bin_out == ALL_ONES);
      end else begin
        bin_p0  = bin_out - 1'b1;
        wrap_p0 = (bin_out == '0);
      end
    end
  end

  // Stage 1: binary and Gray images share one edge so they are always coherent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_out  <= RST_BIN;
      gray_out <= RST_GRAY;
      wrap     <= 1'b0;
    end else begin
      bin_out  <= bin_p0;
      gray_out <= to_gray(bin_p0);
      wrap     <= wrap_p0;
    end
  end

endmodule
